// File: rtl/demux_pkg.sv
// Shared types and constants for the 1-to-2 stream demultiplexer.
package demux_pkg;

  // Packet-routing FSM: IDLE picks the destination per beat, ROUTE holds it locked.
  typedef enum logic {
    IDLE  = 1'b0,
    ROUTE = 1'b1
  } demux_state_t;

  localparam logic SEL_M0 = 1'b0;
  localparam logic SEL_M1 = 1'b1;

endpackage : demux_pkg

// File: rtl/stream_reg_slice.sv
// One-entry registered stream stage: loads on request, drains on downstream ready.
module stream_reg_slice #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] data_i,
  input  logic         last_i,
  input  logic         load_i,
  output logic         can_load_c_o,
  output logic [N-1:0] data_o,
  output logic         last_o,
  output logic         valid_o,
  input  logic         ready_i
);

  logic [N-1:0] data_q, data_d;
  logic         last_q, last_d;
  logic         valid_q, valid_d;

  // Room for a new beat when empty or when the held beat leaves this cycle.
  assign can_load_c_o = !valid_q || ready_i;

  // Next-entry selection: a load wins over a drain and keeps the stage full.
  always_comb begin
    data_d  = data_q;
    last_d  = last_q;
    valid_d = valid_q;
    if (load_i) begin
      data_d  = data_i;
      last_d  = last_i;
      valid_d = 1'b1;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Entry registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign last_o  = last_q;
  assign valid_o = valid_q;

endmodule : stream_reg_slice

// File: rtl/demux_1x2_stream.sv
// 1-to-2 stream demultiplexer; the destination is locked for the whole packet.
module demux_1x2_stream
  import demux_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] s_data,
  input  logic         s_sel,
  input  logic         s_last,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [N-1:0] m0_data,
  output logic         m0_last,
  output logic         m0_valid,
  input  logic         m0_ready,
  output logic [N-1:0] m1_data,
  output logic         m1_last,
  output logic         m1_valid,
  input  logic         m1_ready,
  output logic         busy,
  output logic         cur_sel
);

  demux_state_t state_q, state_d;
  logic         cur_sel_q, cur_sel_d;
  logic         dest_c;
  logic         m0_can_load_c, m1_can_load_c;
  logic         accept_c;
  logic         load0_c, load1_c;

  // Destination: live s_sel on a packet's first beat, the locked select afterwards.
  assign dest_c = (state_q == ROUTE) ? cur_sel_q : s_sel;

  // Input ready follows the destination stage only; held low throughout reset.
  assign s_ready  = !rst && ((dest_c == SEL_M1) ? m1_can_load_c : m0_can_load_c);
  assign accept_c = s_valid && s_ready;
  assign load0_c  = accept_c && (dest_c == SEL_M0);
  assign load1_c  = accept_c && (dest_c == SEL_M1);

  // Packet tracking: a non-last first beat locks the select until the last beat.
  always_comb begin
    state_d   = state_q;
    cur_sel_d = cur_sel_q;
    unique case (state_q)
      IDLE: begin
        if (accept_c && !s_last) begin
          state_d   = ROUTE;
          cur_sel_d = s_sel;
        end
      end
      ROUTE: begin
        if (accept_c && s_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and locked select registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cur_sel_q <= SEL_M0;
    end else begin
      state_q   <= state_d;
      cur_sel_q <= cur_sel_d;
    end
  end

  assign busy    = (state_q == ROUTE);
  assign cur_sel = cur_sel_q;

  stream_reg_slice #(.N(N)) u_slice_m0 (
    .clk          (clk),
    .rst          (rst),
    .data_i       (s_data),
    .last_i       (s_last),
    .load_i       (load0_c),
    .can_load_c_o (m0_can_load_c),
    .data_o       (m0_data),
    .last_o       (m0_last),
    .valid_o      (m0_valid),
    .ready_i      (m0_ready)
  );

  stream_reg_slice #(.N(N)) u_slice_m1 (
    .clk          (clk),
    .rst          (rst),
    .data_i       (s_data),
    .last_i       (s_last),
    .load_i       (load1_c),
    .can_load_c_o (m1_can_load_c),
    .data_o       (m1_data),
    .last_o       (m1_last),
    .valid_o      (m1_valid),
    .ready_i      (m1_ready)
  );

endmodule : demux_1x2_stream

// File: tb/tb_demux_1x2_stream.sv
// Bench for demux_1x2_stream: per-cycle model comparison plus directed literal checks.
module tb_demux_1x2_stream;

  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] s_data = '0;
  logic         s_sel = 1'b0;
  logic         s_last = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [N-1:0] m0_data, m1_data;
  logic         m0_last, m1_last, m0_valid, m1_valid;
  logic         m0_ready = 1'b1;
  logic         m1_ready = 1'b1;
  logic         busy, cur_sel;

  int n_cmp = 0;
  int n_err = 0;

  demux_1x2_stream #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_data   (s_data),
    .s_sel    (s_sel),
    .s_last   (s_last),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .m0_data  (m0_data),
    .m0_last  (m0_last),
    .m0_valid (m0_valid),
    .m0_ready (m0_ready),
    .m1_data  (m1_data),
    .m1_last  (m1_last),
    .m1_valid (m1_valid),
    .m1_ready (m1_ready),
    .busy     (busy),
    .cur_sel  (cur_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each output is a slot (full?, payload); a packet is "open" after a non-last beat.
  logic         mv [2] = '{1'b0, 1'b0};
  logic [N-1:0] md [2] = '{'0, '0};
  logic         ml [2] = '{1'b0, 1'b0};
  logic         in_pkt = 1'b0;
  logic         lsel = 1'b0;
  logic         m_dst, m_acc;
  logic [1:0]   mr;
  assign mr = {m1_ready, m0_ready};

  function automatic logic model_dest();
    return in_pkt ? lsel : s_sel;
  endfunction

  function automatic logic model_ready();
    logic d;
    d = model_dest();
    return !rst && (!mv[d] || mr[d]);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int o = 0; o < 2; o++) begin
        mv[o] = 1'b0;
        md[o] = '0;
        ml[o] = 1'b0;
      end
      in_pkt = 1'b0;
      lsel   = 1'b0;
    end else begin
      m_dst = model_dest();
      m_acc = s_valid && model_ready();
      for (int o = 0; o < 2; o++) begin
        if (m_acc && (m_dst == 1'(o))) begin
          mv[o] = 1'b1;
          md[o] = s_data;
          ml[o] = s_last;
        end else if (mv[o] && mr[o]) begin
          mv[o] = 1'b0;
        end
      end
      if (m_acc) begin
        if (!in_pkt && !s_last) begin
          in_pkt = 1'b1;
          lsel   = s_sel;
        end else if (in_pkt && s_last) begin
          in_pkt = 1'b0;
        end
      end
    end
  end

  // Every cycle, away from the active edge, the DUT must agree with the model.
  always @(negedge clk) begin
    chk("s_ready", 32'(s_ready), 32'(model_ready()));
    chk("busy", 32'(busy), 32'(in_pkt));
    chk("cur_sel", 32'(cur_sel), 32'(lsel));
    chk("m0_valid", 32'(m0_valid), 32'(mv[0]));
    chk("m1_valid", 32'(m1_valid), 32'(mv[1]));
    if (mv[0]) begin
      chk("m0_data", 32'(m0_data), 32'(md[0]));
      chk("m0_last", 32'(m0_last), 32'(ml[0]));
    end
    if (mv[1]) begin
      chk("m1_data", 32'(m1_data), 32'(md[1]));
      chk("m1_last", 32'(m1_last), 32'(ml[1]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] d, input logic sel, input logic last);
    s_data  = d;
    s_sel   = sel;
    s_last  = last;
    s_valid = 1'b1;
  endtask

  initial begin
    // Reset and release.
    tick();
    tick();
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_m0_valid", 32'(m0_valid), 32'd0);
    chk("rst_m1_data", 32'(m1_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_s_ready", 32'(s_ready), 32'd1);

    // Single-beat packets, one per output.
    drive(4'b0001, 1'b0, 1'b1);
    tick();
    s_valid = 1'b0;
    chk("sb0_m0_valid", 32'(m0_valid), 32'd1);
    chk("sb0_m0_data", 32'(m0_data), 32'b0001);
    chk("sb0_m0_last", 32'(m0_last), 32'd1);
    chk("sb0_m1_valid", 32'(m1_valid), 32'd0);
    tick();
    drive(4'b1010, 1'b1, 1'b1);
    tick();
    s_valid = 1'b0;
    chk("sb1_m1_data", 32'(m1_data), 32'b1010);
    chk("sb1_m0_valid", 32'(m0_valid), 32'd0);
    tick();

    // Packet lock: select changes after the first beat are ignored.
    drive(4'b0011, 1'b1, 1'b0);
    tick();
    chk("pk1_busy", 32'(busy), 32'd1);
    chk("pk1_cur_sel", 32'(cur_sel), 32'd1);
    chk("pk1_m1_data", 32'(m1_data), 32'b0011);
    drive(4'b0101, 1'b0, 1'b0);
    tick();
    chk("pk2_m1_data", 32'(m1_data), 32'b0101);
    chk("pk2_m0_valid", 32'(m0_valid), 32'd0);
    drive(4'b1111, 1'b0, 1'b1);
    tick();
    s_valid = 1'b0;
    chk("pk3_m1_data", 32'(m1_data), 32'b1111);
    chk("pk3_m1_last", 32'(m1_last), 32'd1);
    chk("pk3_busy", 32'(busy), 32'd0);
    chk("pk3_cur_sel", 32'(cur_sel), 32'd1);
    tick();

    // Backpressure on m0.
    m0_ready = 1'b0;
    drive(4'b0110, 1'b0, 1'b1);
    tick();
    drive(4'b1001, 1'b0, 1'b1);
    #1;
    chk("bp_s_ready_lo", 32'(s_ready), 32'd0);
    tick();
    chk("bp_m0_hold", 32'(m0_data), 32'b0110);
    chk("bp_m0_valid", 32'(m0_valid), 32'd1);
    m0_ready = 1'b1;
    #1;
    chk("bp_s_ready_hi", 32'(s_ready), 32'd1);
    tick();
    s_valid = 1'b0;
    chk("bp_m0_second", 32'(m0_data), 32'b1001);
    chk("bp_m0_valid2", 32'(m0_valid), 32'd1);
    tick();
    chk("bp_m0_drained", 32'(m0_valid), 32'd0);

    // Cross traffic: m1 still accepts while m0 is stuck full.
    m0_ready = 1'b0;
    drive(4'b0111, 1'b0, 1'b1);
    tick();
    drive(4'b1100, 1'b1, 1'b1);
    #1;
    chk("x_s_ready", 32'(s_ready), 32'd1);
    tick();
    s_valid = 1'b0;
    chk("x_m1_data", 32'(m1_data), 32'b1100);
    chk("x_m0_data", 32'(m0_data), 32'b0111);
    chk("x_m0_valid", 32'(m0_valid), 32'd1);
    m0_ready = 1'b1;
    tick();
    tick();

    // Reset in the middle of a packet to m1.
    drive(4'b0001, 1'b1, 1'b0);
    tick();
    drive(4'b0010, 1'b0, 1'b0);
    tick();
    s_valid  = 1'b0;
    m1_ready = 1'b0;
    chk("mr_busy_pre", 32'(busy), 32'd1);
    chk("mr_m1_full", 32'(m1_valid), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_m1_valid", 32'(m1_valid), 32'd0);
    chk("mr_m1_data", 32'(m1_data), 32'd0);
    chk("mr_s_ready", 32'(s_ready), 32'd0);
    tick();
    rst = 1'b0;
    m1_ready = 1'b1;
    drive(4'b1110, 1'b0, 1'b1);
    tick();
    s_valid = 1'b0;
    chk("mr_m0_data", 32'(m0_data), 32'b1110);
    chk("mr_m1_after", 32'(m1_valid), 32'd0);
    tick();

    // Mixed traffic with random readies, checked by the model every cycle.
    for (int i = 0; i < 400; i++) begin
      s_data   = 4'($urandom_range(0, 15));
      s_sel    = 1'($urandom_range(0, 1));
      s_last   = ($urandom_range(0, 3) == 0);
      s_valid  = 1'($urandom_range(0, 1));
      m0_ready = 1'($urandom_range(0, 1));
      m1_ready = 1'($urandom_range(0, 1));
      tick();
    end
    s_valid  = 1'b0;
    m0_ready = 1'b1;
    m1_ready = 1'b1;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_demux_1x2_stream
